yutorina_instruction_fetch: RTL

Instruction fetch stage of the Yutorina pipeline: owns the program counter, issues word reads to instruction memory over a request/ready handshake, and presents each fetched word with its PC in an IF/ID pipeline register consumed by `yutorina_instruction_decoder`. It supports downstream stall, branch redirect with flush, and variable memory latency, with one outstanding read at a time.

---
 rtl/yutorina_instruction_fetch.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/yutorina_instruction_fetch.sv
// ---------------------------------------------------------------------------
// yutorina_instruction_fetch
//   Instruction fetch stage of the Yutorina pipeline. Owns the PC, issues one
//   outstanding word read at a time to instruction memory (active-low
//   request/ready handshake), and presents each fetched word with its PC in
//   the IF/ID register for yutorina_instruction_decoder. Handles decoder
//   stall through a one-entry skid buffer, and branch redirect through a
//   flush. A read that is already in flight is never cancelled. Its data is
//   discarded on arrival instead.
//
// Ports
//   clk            pipeline clock, rising edge
//   reset_         asynchronous active-low reset
//   stall_         active-low: decoder does not accept if_* this cycle
//   redirect_      active-low branch/jump redirect (flushes the stage)
//   redirect_pc    redirect target, bits [1:0] ignored
//   imem_request_  active-low read request
//   imem_address   word-aligned byte address of the request
//   imem_ready_    active-low: imem_read_data valid this cycle
//   imem_read_data instruction word
//   if_valid_      active-low: if_instruction / if_pc hold a live instruction
//   if_instruction fetched instruction
//   if_pc          byte address of if_instruction
// ---------------------------------------------------------------------------
module yutorina_instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        stall_,
  input  logic        redirect_,
  input  logic [31:0] redirect_pc,
  output logic        imem_request_,
  output logic [31:0] imem_address,
  input  logic        imem_ready_,
  input  logic [31:0] imem_read_data,
  output logic        if_valid_,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc
);

  // FETCH   : request live, its data goes to IF/ID or the skid buffer.
  // BUFFERED: skid buffer full, request idle until the decoder drains IF/ID.
  // DISCARD : request live, but its data belongs to a flushed path.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FETCH    = 2'd1,
    S_BUFFERED = 2'd2,
    S_DISCARD  = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;          // address in flight, or next to request
  logic [31:0] r_buf_instr;   // skid entry
  logic [31:0] r_buf_pc;
  logic [31:0] r_pending_pc;  // redirect target parked while DISCARD drains
  logic        r_if_valid_;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;

  logic        w_redir;
  logic        w_rdata;
  logic        w_accept;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_next;

  assign w_redir       = ~redirect_;
  assign w_rdata       = ~imem_ready_;
  // IF/ID can take a new word when empty or when the decoder takes the
  // current one at this edge.
  assign w_accept      = r_if_valid_ | stall_;
  assign w_redirect_pc = redirect_pc & ~32'h0000_0003;
  assign w_pc_next     = r_pc + 32'd4;   // wraps modulo 2^32

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_VECTOR;
      r_buf_instr  <= '0;
      r_buf_pc     <= '0;
      r_pending_pc <= '0;
      r_if_valid_  <= 1'b1;
      r_if_instr   <= '0;
      r_if_pc      <= '0;
    end else begin
      // Decoder consumes a live word; a load below overrides this.
      if (!r_if_valid_ && stall_) r_if_valid_ <= 1'b1;
      // A redirect kills whatever sits in IF/ID, stalled or not.
      if (w_redir) r_if_valid_ <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_redir) r_pc <= w_redirect_pc;
          r_state <= S_FETCH;
        end

        S_FETCH: begin
          if (w_rdata) begin
            if (w_redir) begin
              // Returned word is on the wrong path: drop it and re-aim.
              r_pc <= w_redirect_pc;
            end else if (w_accept) begin
              r_if_instr  <= imem_read_data;
              r_if_pc     <= r_pc;
              r_if_valid_ <= 1'b0;
              r_pc        <= w_pc_next;
            end else begin
              // Decoder is stalled on a live word: park this one.
              r_buf_instr <= imem_read_data;
              r_buf_pc    <= r_pc;
              r_pc        <= w_pc_next;
              r_state     <= S_BUFFERED;
            end
          end else if (w_redir) begin
            // Cannot re-address a live request; let it finish and drop it.
            r_pending_pc <= w_redirect_pc;
            r_state      <= S_DISCARD;
          end
        end

        S_BUFFERED: begin
          if (w_redir) begin
            r_pc    <= w_redirect_pc;
            r_state <= S_FETCH;
          end else if (stall_) begin
            r_if_instr  <= r_buf_instr;
            r_if_pc     <= r_buf_pc;
            r_if_valid_ <= 1'b0;
            r_state     <= S_FETCH;
          end
        end

        S_DISCARD: begin
          if (w_rdata) begin
            // A redirect arriving with the data is the newest target.
            r_pc    <= w_redir ? w_redirect_pc : r_pending_pc;
            r_state <= S_FETCH;
          end else if (w_redir) begin
            r_pending_pc <= w_redirect_pc;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Request is decoded from registered state only, so it has no
  // combinational dependence on stall_ or redirect_.
  assign imem_request_  = ~((r_state == S_FETCH) || (r_state == S_DISCARD));
  assign imem_address   = r_pc;
  assign if_valid_      = r_if_valid_;
  assign if_instruction = r_if_instr;
  assign if_pc          = r_if_pc;

endmodule
